// File: rtl/rx32_ctrl_pkg.sv
// Shared definitions for the Rx32 multicycle control path: FSM states,
// instruction opcodes, ALUOp encodings and mux-select encodings.
package rx32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that own the memory bus and are subject to the wait timer.
    function automatic logic is_mem_state(input state_e s);
        case (s)
            S_FETCH, S_MEMRD, S_MEMWR: is_mem_state = 1'b1;
            default:                   is_mem_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of one memory access and flags when the limit is reached.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle Rx32 core. Sequences fetch, decode, execute,
// memory and writeback one instruction at a time over a shared datapath.
module multicycle_controller
    import rx32_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal,
    output logic       bus_error
);

    state_e state_q;
    state_e state_d;
    logic   in_mem_s;
    logic   timeout_s;
    logic   expired_s;
    logic   legal_op_s;

    assign in_mem_s = is_mem_state(state_q);
    // A ready in the limit cycle completes the access instead of timing out.
    assign expired_s = in_mem_s & ~mem_ready & timeout_s;

    // Any state change (including a refetch after timeout) starts a fresh wait count.
    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_d != state_q) | expired_s),
        .inc     (in_mem_s & ~mem_ready),
        .timeout (timeout_s)
    );

    // Opcode legality check used by DECODE.
    always_comb begin
        case (OPCode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_J:          legal_op_s = 1'b1;
            default:                         legal_op_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (OPCode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI: state_d = S_IMMEX;
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (OPCode == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (expired_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready || expired_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB,
            S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        mem_req   = 1'b0;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        Branch    = 1'b0;
        PCSrc     = PCSRC_ALU;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RT;
        ALUOp     = ALUOP_ADD;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        bus_error = 1'b0;
        if (reset) begin
            mem_req = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = ~expired_s;
                    ALUSrcB   = SRCB_FOUR;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    bus_error = expired_s;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    illegal = ~legal_op_s;
                end
                S_MEMADR, S_IMMEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_req   = ~expired_s;
                    IorD      = 1'b1;
                    bus_error = expired_s;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = ~expired_s;
                    IorD      = 1'b1;
                    MemWrite  = ~expired_s;
                    bus_error = expired_s;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_SUB;
                    PCSrc   = PCSRC_ALUOUT;
                    Branch  = 1'b1;
                end
                S_IMMWB: begin
                    RegWrite = 1'b1;
                end
                S_JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed test of multicycle_controller with a short memory timeout (4 cycles).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OPCode;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic       ALUSrcA, RegDst, MemtoReg, RegWrite, illegal, bus_error;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BAD   = 6'b111111;

    // Output vector layout:
    // mem_req IorD MemWrite IRWrite PCWrite Branch PCSrc[2] ALUSrcA ALUSrcB[2] ALUOp[2] RegDst MemtoReg RegWrite illegal bus_error
    localparam logic [17:0] E_ZERO     = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] E_FETCH_R  = 18'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] E_FETCH_W  = 18'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] E_FETCH_TO = 18'b0_0_0_0_0_0_00_0_01_00_0_0_0_0_1;
    localparam logic [17:0] E_DECODE   = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
    localparam logic [17:0] E_DEC_ILL  = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_1_0;
    localparam logic [17:0] E_MEMADR   = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] E_MEMRD    = 18'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] E_MEMWB    = 18'b0_0_0_0_0_0_00_0_00_00_0_1_1_0_0;
    localparam logic [17:0] E_MEMWR    = 18'b1_1_1_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] E_EXEC     = 18'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0;
    localparam logic [17:0] E_ALUWB    = 18'b0_0_0_0_0_0_00_0_00_00_1_0_1_0_0;
    localparam logic [17:0] E_BRANCH   = 18'b0_0_0_0_0_1_01_1_00_01_0_0_0_0_0;
    localparam logic [17:0] E_IMMEX    = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] E_IMMWB    = 18'b0_0_0_0_0_0_00_0_00_00_0_0_1_0_0;
    localparam logic [17:0] E_JUMP     = 18'b0_0_0_0_1_0_10_0_00_00_0_0_0_0_0;

    logic [17:0] outs_s;
    assign outs_s = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
                     ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
                     illegal, bus_error};

    multicycle_controller #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .OPCode    (OPCode),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .PCSrc     (PCSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .illegal   (illegal),
        .bus_error (bus_error)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, then advance past the edge.
    task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                        input logic [17:0] exp);
        mem_ready = rdy;
        OPCode    = op;
        @(negedge clk);
        check(tag, {14'd0, outs_s}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        OPCode    = T_RTYPE;
        @(posedge clk);
        #1;
        // Reset held three cycles with memory ready: everything low.
        for (int i = 0; i < 3; i++) begin
            step("reset", 1'b1, T_LW, E_ZERO);
        end
        reset = 1'b0;

        // lw, zero-wait: 5 cycles.
        step("lw_fetch",  1'b1, T_LW, E_FETCH_R);
        step("lw_decode", 1'b1, T_LW, E_DECODE);
        step("lw_memadr", 1'b1, T_LW, E_MEMADR);
        step("lw_memrd",  1'b1, T_LW, E_MEMRD);
        step("lw_memwb",  1'b1, T_LW, E_MEMWB);

        // sw with three wait cycles in MEMWR.
        step("sw_fetch",  1'b1, T_SW, E_FETCH_R);
        step("sw_decode", 1'b1, T_SW, E_DECODE);
        step("sw_memadr", 1'b1, T_SW, E_MEMADR);
        step("sw_wait1",  1'b0, T_SW, E_MEMWR);
        step("sw_wait2",  1'b0, T_SW, E_MEMWR);
        step("sw_wait3",  1'b0, T_SW, E_MEMWR);
        step("sw_done",   1'b1, T_SW, E_MEMWR);

        // R-type.
        step("r_fetch",  1'b1, T_RTYPE, E_FETCH_R);
        step("r_decode", 1'b1, T_RTYPE, E_DECODE);
        step("r_exec",   1'b1, T_RTYPE, E_EXEC);
        step("r_aluwb",  1'b1, T_RTYPE, E_ALUWB);

        // beq.
        step("beq_fetch",  1'b1, T_BEQ, E_FETCH_R);
        step("beq_decode", 1'b1, T_BEQ, E_DECODE);
        step("beq_branch", 1'b1, T_BEQ, E_BRANCH);

        // j.
        step("j_fetch",  1'b1, T_J, E_FETCH_R);
        step("j_decode", 1'b1, T_J, E_DECODE);
        step("j_jump",   1'b1, T_J, E_JUMP);

        // addi.
        step("addi_fetch",  1'b1, T_ADDI, E_FETCH_R);
        step("addi_decode", 1'b1, T_ADDI, E_DECODE);
        step("addi_immex",  1'b1, T_ADDI, E_IMMEX);
        step("addi_immwb",  1'b1, T_ADDI, E_IMMWB);

        // Illegal opcode: one-cycle pulse, straight back to FETCH.
        step("ill_fetch",  1'b1, T_BAD, E_FETCH_R);
        step("ill_decode", 1'b1, T_BAD, E_DEC_ILL);
        step("ill_refetch_wait", 1'b0, T_BAD, E_FETCH_W);

        // Continue waiting: that was wait cycle 1; cycles 2..4 then timeout on 5th.
        step("to_wait2", 1'b0, T_LW, E_FETCH_W);
        step("to_wait3", 1'b0, T_LW, E_FETCH_W);
        step("to_wait4", 1'b0, T_LW, E_FETCH_W);
        step("to_error", 1'b0, T_LW, E_FETCH_TO);
        // Refetch with a fresh count: four waits, ready in the limit cycle wins.
        step("re_wait1", 1'b0, T_LW, E_FETCH_W);
        step("re_wait2", 1'b0, T_LW, E_FETCH_W);
        step("re_wait3", 1'b0, T_LW, E_FETCH_W);
        step("re_wait4", 1'b0, T_LW, E_FETCH_W);
        step("re_ready_at_limit", 1'b1, T_LW, E_FETCH_R);
        step("re_decode", 1'b1, T_LW, E_DECODE);

        // Timeout during a load read, then reset mid-access.
        step("rdto_memadr", 1'b1, T_LW, E_MEMADR);
        step("rdto_wait1", 1'b0, T_LW, E_MEMRD);
        step("rdto_wait2", 1'b0, T_LW, E_MEMRD);
        step("rdto_wait3", 1'b0, T_LW, E_MEMRD);
        step("rdto_wait4", 1'b0, T_LW, E_MEMRD);
        step("rdto_error", 1'b0, T_LW, 18'b0_1_0_0_0_0_00_0_00_00_0_0_0_0_1);
        step("rdto_refetch", 1'b1, T_LW, E_FETCH_R);
        step("rst_decode", 1'b1, T_LW, E_DECODE);
        step("rst_memadr", 1'b1, T_LW, E_MEMADR);
        reset = 1'b1;
        step("rst_mid_access", 1'b0, T_LW, E_ZERO);
        reset = 1'b0;
        step("rst_then_fetch", 1'b1, T_LW, E_FETCH_R);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
